mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter BURST, default 2, meaning the number of dcache words per grant (block transfer length).
REQ-002 SHALL have port CLK  in  1  clock, rising-edge.
REQ-003 SHALL have port nRST  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports iREN in 1, iaddr in 32, iload out 32, iwait out 1, forming the icache request port.
REQ-005 SHALL have ports dREN in 1, dWEN in 1, daddr in 32, dstore in 32, dload out 32, dwait out 1, forming the dcache request port.
REQ-006 SHALL have ports ramREN out 1, ramWEN out 1, ramaddr out 32, ramstore out 32, ramload in 32, ramstate in 2 (FREE/BUSY/ACCESS/ERROR), forming the RAM port.
REQ-007 SHALL have port bus_err  out  1: sticky flag set on ramstate==ERROR.

Function
REQ-008 SHALL implement FSM states IDLE, DGNT, IGNT.
REQ-009 IDLE: ram enables 0; iwait=dwait=1; no RAM request issued.
REQ-010 IDLE->DGNT when (dREN|dWEN) and (not iREN, or last_owner==I); IDLE->IGNT when iREN and (no dcache request, or last_owner==D).
REQ-011 Arbitration SHALL be registered: grant takes effect the cycle after the request is seen in IDLE (1-cycle arbitration latency).
REQ-012 DGNT: ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN (write wins on simultaneous dREN/dWEN); dload=ramload.
REQ-013 IGNT: ramaddr=iaddr, ramREN=iREN, ramWEN=0, ramstore=0; iload=ramload.
REQ-014 Granted side's wait SHALL be 0 only in a cycle where ramstate==ACCESS; the non-granted side's wait SHALL be 1.
REQ-015 A word completes on a cycle with the grant held, the request asserted, and ramstate==ACCESS; a 2-bit-wide word counter SHALL increment on each completion.
REQ-016 DGNT SHALL hold the grant until BURST words complete, then go to IDLE, clear the counter, and set last_owner=D.
REQ-017 IGNT SHALL return to IDLE after 1 word completes and set last_owner=I.
REQ-018 Requester dropping its enables mid-grant SHALL return the FSM to IDLE next cycle, clear the counter, and leave last_owner unchanged.
REQ-019 ramstate BUSY/FREE SHALL hold state and counter; ERROR SHALL hold wait=1, keep the request asserted, and set bus_err until reset.
REQ-020 iload/dload SHALL be 0 when their side is not granted.

Reset
REQ-021 Asserting nRST, including mid-burst, SHALL immediately force: state=IDLE, counter=0, last_owner=I (dcache wins first tie), bus_err=0, ramREN=ramWEN=0, iwait=dwait=1.
REQ-022 After reset release, the first arbitration SHALL occur on the first rising edge with a request present.

Structure
REQ-023 The ramstate enum (FREE, BUSY, ACCESS, ERROR) and word_t SHALL come from the shared cpu types package; the FSM state enum SHALL be local to the module.
REQ-024 The block SHALL be a single module with no sub-modules; output muxing SHALL be combinational from the registered state.

Verification
REQ-025 Dcache-only read, BURST=2, RAM returning ACCESS every 2nd cycle: daddr 0x100 then 0x104 -> dwait low exactly twice, dload=ramload, FSM returns to IDLE, icache never granted.
REQ-026 iREN and dREN raised together after reset: dcache granted first; after its 2 words complete, icache granted on the next arbitration; iwait stays 1 throughout the dcache burst.
REQ-027 Back-to-back conflicting requests over 4 arbitrations, with both ports requesting continuously: grants alternate D, I, D, I.
REQ-028 dREN=dWEN=1 with daddr=0x3100 and dstore=0xDEADBEEF: ramWEN=1, ramREN=0, ramstore=0xDEADBEEF.
REQ-029 nRST pulsed low after the first of 2 dcache words: ram enables drop asynchronously; the next request restarts at word count 0.
REQ-030 ramstate=ERROR for 3 cycles in IGNT: iwait=1, bus_err=1 and stays 1; the word completes when ACCESS follows.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared CPU memory-bus types: word width, RAM handshake state and bus owner.
package mem_arbiter_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (icache/dcache) arbiter in front of a single RAM port.
// Dcache owns the bus for BURST words per grant; ties alternate by last owner.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int BURST = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    // icache port
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    // dcache port
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    // RAM port
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DGNT = 2'd1,
        IGNT = 2'd2
    } state_t;

    localparam logic [1:0] LAST_WORD = 2'(BURST - 1);

    state_t    state, state_next;
    logic [1:0] word_cnt, word_cnt_next;
    owner_t    last_owner, last_owner_next;
    ramstate_t rstate;
    logic      dreq;
    logic      access;

    assign rstate = ramstate_t'(ramstate);
    assign dreq   = dREN | dWEN;
    assign access = (rstate == ACCESS);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            word_cnt   <= 2'd0;
            last_owner <= OWNER_I;
            bus_err    <= 1'b0;
        end else begin
            state      <= state_next;
            word_cnt   <= word_cnt_next;
            last_owner <= last_owner_next;
            if (rstate == ERROR)
                bus_err <= 1'b1;
        end
    end

    // A dropped enable abandons the grant without changing fairness history.
    always_comb begin
        state_next      = state;
        word_cnt_next   = word_cnt;
        last_owner_next = last_owner;
        case (state)
            IDLE: begin
                if (dreq && (!iREN || last_owner == OWNER_I))
                    state_next = DGNT;
                else if (iREN)
                    state_next = IGNT;
            end
            DGNT: begin
                if (!dreq) begin
                    state_next    = IDLE;
                    word_cnt_next = 2'd0;
                end else if (access) begin
                    if (word_cnt == LAST_WORD) begin
                        state_next      = IDLE;
                        word_cnt_next   = 2'd0;
                        last_owner_next = OWNER_D;
                    end else begin
                        word_cnt_next = word_cnt + 2'd1;
                    end
                end
            end
            IGNT: begin
                if (!iREN) begin
                    state_next    = IDLE;
                    word_cnt_next = 2'd0;
                end else if (access) begin
                    state_next      = IDLE;
                    word_cnt_next   = 2'd0;
                    last_owner_next = OWNER_I;
                end
            end
            default: begin
                state_next    = IDLE;
                word_cnt_next = 2'd0;
            end
        endcase
    end

    // Write wins when the dcache raises both enables together.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        iload    = 32'd0;
        dload    = 32'd0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        case (state)
            DGNT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                dload    = ramload;
                dwait    = ~access;
            end
            IGNT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                iload   = ramload;
                iwait   = ~access;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: drivers queue expected words, a monitor checks completions.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam logic [31:0] KEY = 32'hC0DE_0000;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore;
    logic [31:0] iload, dload;
    logic        iwait, dwait;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;
    logic        bus_err;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_d[$];
    logic [31:0] exp_i[$];
    bit          exp_side[$];   // 1 = dcache word, 0 = icache word
    int          err_cycles = 0;
    bit          phase = 1'b0;

    always #5 CLK = ~CLK;

    // RAM returns a value derived from the address it is given.
    assign ramload = ramaddr ^ KEY;

    mem_arbiter #(.BURST(2)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .bus_err(bus_err)
    );

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%b want=%b", name, act, exp);
        end
    endtask

    // RAM responder: BUSY then ACCESS alternately while enabled, optional ERROR cycles first.
    initial begin
        ramstate = FREE;
        forever begin
            @(posedge CLK);
            #2;
            if (!(ramREN || ramWEN)) begin
                ramstate = FREE;
                phase    = 1'b0;
            end else if (err_cycles > 0) begin
                ramstate = ERROR;
                err_cycles--;
            end else begin
                ramstate = phase ? ACCESS : BUSY;
                phase    = ~phase;
            end
        end
    end

    // Monitor: every completed word is checked against the scoreboard.
    always @(negedge CLK) begin
        if (nRST === 1'b1) begin
            if (!dwait) begin
                if (exp_side.size() == 0 || exp_d.size() == 0) begin
                    total++; bad++;
                    $display("FAIL d_unexpected: got=dcache word %h want=none", dload);
                end else begin
                    chk1("grant_side_d", 1'b1, exp_side.pop_front());
                    chk32("dload", dload, exp_d.pop_front());
                end
                chk1("iwait_during_d", iwait, 1'b1);
                chk32("iload_during_d", iload, 32'd0);
            end
            if (!iwait) begin
                if (exp_side.size() == 0 || exp_i.size() == 0) begin
                    total++; bad++;
                    $display("FAIL i_unexpected: got=icache word %h want=none", iload);
                end else begin
                    chk1("grant_side_i", 1'b0, exp_side.pop_front());
                    chk32("iload", iload, exp_i.pop_front());
                end
                chk1("dwait_during_i", dwait, 1'b1);
                chk32("dload_during_i", dload, 32'd0);
            end
        end
    end

    task automatic wait_dword();
        for (int n = 0; n < 60; n++) begin
            @(negedge CLK);
            if (!dwait) return;
        end
        total++; bad++;
        $display("FAIL dword_timeout: got=no dwait low want=completion within 60 cycles");
    endtask

    task automatic wait_iword();
        for (int n = 0; n < 60; n++) begin
            @(negedge CLK);
            if (!iwait) return;
        end
        total++; bad++;
        $display("FAIL iword_timeout: got=no iwait low want=completion within 60 cycles");
    endtask

    task automatic d_burst(input logic [31:0] base, input int n);
        dREN = 1'b1;
        dWEN = 1'b0;
        for (int k = 0; k < n; k++) begin
            daddr = base + 32'(4 * k);
            exp_d.push_back(daddr ^ KEY);
            wait_dword();
            @(posedge CLK); #1;
        end
        dREN = 1'b0;
    endtask

    task automatic i_fetch(input logic [31:0] base, input int n);
        iREN = 1'b1;
        for (int k = 0; k < n; k++) begin
            iaddr = base + 32'(4 * k);
            exp_i.push_back(iaddr ^ KEY);
            wait_iword();
            @(posedge CLK); #1;
        end
        iREN = 1'b0;
    endtask

    task automatic do_reset();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0;
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
    endtask

    initial begin
        nRST = 1'b0;
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0;
        #1;
        chk1("rst_ramREN", ramREN, 1'b0);
        chk1("rst_ramWEN", ramWEN, 1'b0);
        chk1("rst_iwait", iwait, 1'b1);
        chk1("rst_dwait", dwait, 1'b1);
        chk1("rst_bus_err", bus_err, 1'b0);
        chk32("rst_dload", dload, 32'd0);
        chk32("rst_iload", iload, 32'd0);
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;

        // dcache-only two-word read
        exp_side.push_back(1'b1); exp_side.push_back(1'b1);
        d_burst(32'h100, 2);
        repeat (2) @(posedge CLK);
        #1;
        chk1("idle_after_burst_ramREN", ramREN, 1'b0);
        chk1("idle_after_burst_dwait", dwait, 1'b1);

        // simultaneous requests after reset: dcache first
        do_reset();
        exp_side.push_back(1'b1); exp_side.push_back(1'b1); exp_side.push_back(1'b0);
        fork
            d_burst(32'h400, 2);
            i_fetch(32'h800, 1);
        join

        // continuous contention: D, I, D, I
        do_reset();
        exp_side.push_back(1'b1); exp_side.push_back(1'b1); exp_side.push_back(1'b0);
        exp_side.push_back(1'b1); exp_side.push_back(1'b1); exp_side.push_back(1'b0);
        fork
            d_burst(32'h1000, 4);
            i_fetch(32'h2000, 2);
        join

        // write wins on dREN=dWEN=1
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h3100; dstore = 32'hDEADBEEF;
        exp_side.push_back(1'b1); exp_side.push_back(1'b1);
        exp_d.push_back(32'h3100 ^ KEY);
        @(negedge CLK);
        @(negedge CLK);
        chk1("wr_ramWEN", ramWEN, 1'b1);
        chk1("wr_ramREN", ramREN, 1'b0);
        chk32("wr_ramstore", ramstore, 32'hDEADBEEF);
        chk32("wr_ramaddr", ramaddr, 32'h3100);
        wait_dword();
        @(posedge CLK); #1;
        daddr = 32'h3104; dstore = 32'hCAFEF00D;
        exp_d.push_back(32'h3104 ^ KEY);
        wait_dword();
        chk32("wr_ramstore2", ramstore, 32'hCAFEF00D);
        @(posedge CLK); #1;
        dREN = 1'b0; dWEN = 1'b0;

        // reset in the middle of a burst
        exp_side.push_back(1'b1);
        exp_d.push_back(32'h200 ^ KEY);
        dREN = 1'b1; daddr = 32'h200;
        wait_dword();
        @(posedge CLK);
        #3 nRST = 1'b0;
        #1;
        chk1("midrst_ramREN", ramREN, 1'b0);
        chk1("midrst_dwait", dwait, 1'b1);
        chk1("midrst_iwait", iwait, 1'b1);
        dREN = 1'b0;
        @(posedge CLK);
        #1 nRST = 1'b1;
        exp_side.push_back(1'b1); exp_side.push_back(1'b1);
        dREN = 1'b1; daddr = 32'h300;
        exp_d.push_back(32'h300 ^ KEY);
        wait_dword();
        @(posedge CLK); #1;
        chk1("restart_still_granted", ramREN, 1'b1);
        daddr = 32'h304;
        exp_d.push_back(32'h304 ^ KEY);
        wait_dword();
        @(posedge CLK); #1;
        dREN = 1'b0;

        // ERROR cycles during an icache grant
        exp_side.push_back(1'b0);
        exp_i.push_back(32'h500 ^ KEY);
        err_cycles = 3;
        iREN = 1'b1; iaddr = 32'h500;
        @(negedge CLK);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk1("err_iwait", iwait, 1'b1);
            chk1("err_ramREN", ramREN, 1'b1);
        end
        chk1("err_bus_err", bus_err, 1'b1);
        wait_iword();
        @(posedge CLK); #1;
        iREN = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk1("bus_err_sticky", bus_err, 1'b1);
        nRST = 1'b0;
        #1;
        chk1("bus_err_cleared", bus_err, 1'b0);
        @(posedge CLK);
        #1 nRST = 1'b1;
        repeat (2) @(posedge CLK);

        chk32("exp_d_drained", 32'(exp_d.size()), 32'd0);
        chk32("exp_i_drained", 32'(exp_i.size()), 32'd0);
        chk32("exp_side_drained", 32'(exp_side.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
